pdp8l_xbr_arbiter: RTL

//  Owns the external 32Kx12 block RAM bus and shares it between three requesters:
//  the CPU-side extended memory controller (absolute priority), the ARM register

---
 rtl/pdp8l_xbr_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pdp8l_xbr_arbiter.sv
// pdp8l_xbr_arbiter
// Owns the external 32Kx12 block RAM bus. The CPU memory controller has
// absolute priority and passes straight through combinationally. ARM register
// port accesses and DMA accesses are fitted into idle gaps of the CPU memory
// cycle and take turns with each other.
//
//  state   | meaning
//  S_IDLE  | RAM free for the CPU; start a secondary access when the CPU cycle is idle
//  S_GRANT | secondary access owns the RAM for RAMLAT clocks; read data taken on the last one
//  S_DONE  | one clock with the RAM enable low; results already posted to ARM/DMA side
module pdp8l_xbr_arbiter #(
    parameter int          RAMLAT  = 2,
    parameter logic [11:0] VERSION = 12'd1
) (
    input  logic        CLOCK,
    input  logic        RESET,

    input  logic        cpu_busy,
    input  logic        cpu_enab,
    input  logic        cpu_wena,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_wdat,
    output logic [11:0] cpu_rdat,

    input  logic        dma_req,
    input  logic        dma_wena,
    input  logic [14:0] dma_addr,
    input  logic [11:0] dma_wdat,
    output logic [11:0] dma_rdat,
    output logic        dma_ack,

    input  logic        armwrite,
    input  logic [1:0]  armwaddr,
    input  logic [1:0]  armraddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,

    output logic [14:0] xbraddr,
    output logic [11:0] xbrwdat,
    input  logic [11:0] xbrrdat,
    output logic        xbrenab,
    output logic        xbrwena
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Grant timer is a down-counter loaded with RAMLAT-1; terminal count is zero.
    localparam logic [2:0]  LAT_LOAD = 3'(RAMLAT - 1);
    localparam logic [31:0] IDENT    = {16'h5841, 4'h1, VERSION};

    state_t      state;
    logic [2:0]  grant_cnt;
    logic        grant_arm;     // current grant belongs to the ARM port
    logic        last_arm;      // most recently completed access was ARM

    // Registered secondary-side RAM drive
    logic        g_enab;
    logic        g_wena;
    logic [14:0] g_addr;
    logic [11:0] g_wdat;

    // Queued ARM access
    logic        arm_busy;
    logic        arm_ovrrun;
    logic        arm_wr;
    logic [14:0] arm_addr;
    logic [11:0] arm_wdat;

    // Result of the last completed ARM access
    logic        last_wr;
    logic [14:0] last_addr;
    logic [11:0] last_rdat;

    logic [15:0] conflicts;
    logic [7:0]  armcycles;
    logic [7:0]  dmacycles;

    logic        sec_pending;
    logic        pick_arm;
    logic [11:0] grant_rdat;
    logic        unused_armwdata;

    assign sec_pending = arm_busy | dma_req;
    // On a tie the port that was not served last wins; DMA counts as last after reset.
    assign pick_arm    = arm_busy & (~dma_req | ~last_arm);
    // A write reports back the data it stored; a read reports what the RAM returned.
    assign grant_rdat  = g_wena ? g_wdat : xbrrdat;

    assign unused_armwdata = ^{armwdata[30:29], armwdata[13:12]};

    // CPU owns the RAM combinationally whenever it enables it
    assign xbrenab  = cpu_enab | g_enab;
    assign xbrwena  = cpu_enab ? cpu_wena : g_wena;
    assign xbraddr  = cpu_enab ? cpu_addr : g_addr;
    assign xbrwdat  = cpu_enab ? cpu_wdat : g_wdat;
    assign cpu_rdat = xbrrdat;

    // Arbiter state machine, grant timer, result posting and ARM register writes
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= S_IDLE;
            grant_cnt  <= 3'd0;
            grant_arm  <= 1'b0;
            last_arm   <= 1'b0;
            g_enab     <= 1'b0;
            g_wena     <= 1'b0;
            g_addr     <= 15'd0;
            g_wdat     <= 12'd0;
            dma_ack    <= 1'b0;
            dma_rdat   <= 12'd0;
            arm_busy   <= 1'b0;
            arm_ovrrun <= 1'b0;
            arm_wr     <= 1'b0;
            arm_addr   <= 15'd0;
            arm_wdat   <= 12'd0;
            last_wr    <= 1'b0;
            last_addr  <= 15'd0;
            last_rdat  <= 12'd0;
            conflicts  <= 16'd0;
            armcycles  <= 8'd0;
            dmacycles  <= 8'd0;
        end else begin
            dma_ack <= 1'b0;

            case (state)
                S_IDLE: begin
                    g_enab <= 1'b0;
                    g_wena <= 1'b0;
                    // cpu_enab also blocks a start: the CPU would only steal it back next clock
                    if (!cpu_busy && !cpu_enab && sec_pending) begin
                        state     <= S_GRANT;
                        grant_cnt <= LAT_LOAD;
                        g_enab    <= 1'b1;
                        grant_arm <= pick_arm;
                        if (pick_arm) begin
                            g_wena <= arm_wr;
                            g_addr <= arm_addr;
                            g_wdat <= arm_wdat;
                        end else begin
                            g_wena <= dma_wena;
                            g_addr <= dma_addr;
                            g_wdat <= dma_wdat;
                        end
                    end
                end

                S_GRANT: begin
                    if (cpu_enab) begin
                        // CPU took the RAM mid-access: abandon it, requester stays pending
                        state  <= S_IDLE;
                        g_enab <= 1'b0;
                        g_wena <= 1'b0;
                        if (conflicts != 16'hFFFF) begin
                            conflicts <= conflicts + 16'd1;
                        end
                    end else if (grant_cnt == 3'd0) begin
                        state  <= S_DONE;
                        g_enab <= 1'b0;
                        g_wena <= 1'b0;
                        if (grant_arm) begin
                            arm_busy  <= 1'b0;
                            last_wr   <= g_wena;
                            last_addr <= g_addr;
                            last_rdat <= grant_rdat;
                            armcycles <= armcycles + 8'd1;
                            last_arm  <= 1'b1;
                        end else begin
                            dma_ack   <= 1'b1;
                            dma_rdat  <= grant_rdat;
                            dmacycles <= dmacycles + 8'd1;
                            last_arm  <= 1'b0;
                        end
                    end else begin
                        grant_cnt <= grant_cnt - 3'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    g_enab <= 1'b0;
                    g_wena <= 1'b0;
                end
            endcase

            // ARM register writes come after the FSM so a counter clear wins over an increment
            if (armwrite) begin
                case (armwaddr)
                    2'd1: begin
                        if (arm_busy) begin
                            arm_ovrrun <= 1'b1;
                        end else begin
                            arm_busy <= 1'b1;
                            arm_wr   <= armwdata[31];
                            arm_addr <= armwdata[28:14];
                            arm_wdat <= armwdata[11:0];
                        end
                    end
                    2'd2: begin
                        conflicts  <= 16'd0;
                        armcycles  <= 8'd0;
                        dmacycles  <= 8'd0;
                        arm_ovrrun <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ARM register read mux
    always_comb begin
        armrdata = 32'h0000_0000;
        case (armraddr)
            2'd0:    armrdata = IDENT;
            2'd1:    armrdata = {arm_busy, arm_ovrrun, last_wr, last_addr, 2'b00, last_rdat};
            2'd2:    armrdata = {conflicts, armcycles, dmacycles};
            default: armrdata = 32'h0000_0000;
        endcase
    end

endmodule
